// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row sampling, whole-scan debounce,
// ghost rejection and single-cycle key_valid per confirmed press.
module keypad_scan_ctrl #(
   parameter int SCAN_DIV       = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      CONFIRM_PRESS,
      HELD,
      CONFIRM_RELEASE
   } state_t;

   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [DW-1:0] dwell;
   logic [1:0]    col_idx;
   logic [1:0]    col_nxt;
   logic [15:0]   snap;
   logic [15:0]   snap_next;
   logic          dwell_end;
   logic          eos;

   state_t        state;
   state_t        state_n;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic [CW-1:0] cnt_inc;
   logic [3:0]    cand;
   logic [3:0]    cand_n;
   logic [3:0]    code_n;
   logic          valid_n;

   logic [1:0]    nz;
   logic [3:0]    hit;
   logic [3:0]    key;
   logic          single;
   logic          match;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 4'hF;
         sync2 <= 4'hF;
      end else begin
         sync1 <= row_in;
         sync2 <= sync1;
      end
   end

   assign dwell_end = (dwell == DWELL_MAX);
   assign eos       = dwell_end && (col_idx == 2'd3);
   assign col_nxt   = col_idx + 2'd1;

   always_comb begin
      snap_next = snap;
      if (dwell_end) begin
         snap_next[{col_idx, 2'b00} +: 4] = sync2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dwell   <= '0;
         col_idx <= 2'd0;
         col_out <= 4'b1110;
         snap    <= '1;
      end else if (dwell_end) begin
         dwell   <= '0;
         col_idx <= col_nxt;
         col_out <= ~(4'b0001 << col_nxt);
         snap    <= snap_next;
      end else begin
         dwell   <= dwell + 1'b1;
      end
   end

   // Classify the full scan including the column being latched this edge.
   // Snapshot bit i sits at col=i[3:2], row=i[1:0].
   always_comb begin
      nz  = 2'd0;
      hit = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (!snap_next[i]) begin
            hit = 4'(i);
            if (nz != 2'd2) begin
               nz = nz + 2'd1;
            end
         end
      end
   end

   assign key     = {hit[1:0], hit[3:2]};
   assign single  = (nz == 2'd1);
   assign match   = single && (key == cand);
   assign cnt_inc = cnt + CNT_ONE;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      cand_n  = cand;
      code_n  = key_code;
      valid_n = 1'b0;
      if (eos) begin
         unique case (state)
            IDLE: begin
               if (single) begin
                  cand_n = key;
                  cnt_n  = CNT_ONE;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_n = HELD;
                     code_n  = key;
                     valid_n = 1'b1;
                  end else begin
                     state_n = CONFIRM_PRESS;
                  end
               end
            end
            CONFIRM_PRESS: begin
               if (match) begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state_n = HELD;
                     code_n  = cand;
                     valid_n = 1'b1;
                  end
               end else if (single) begin
                  cand_n = key;
                  cnt_n  = CNT_ONE;
               end else begin
                  state_n = IDLE;
               end
            end
            HELD: begin
               if (!match) begin
                  cnt_n = CNT_ONE;
                  if (DEBOUNCE_SCANS == 1) begin
                     state_n = IDLE;
                  end else begin
                     state_n = CONFIRM_RELEASE;
                  end
               end
            end
            CONFIRM_RELEASE: begin
               if (match) begin
                  state_n = HELD;
               end else begin
                  cnt_n = cnt_inc;
                  if (cnt_inc == CNT_MAX) begin
                     state_n = IDLE;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cand      <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cand      <= cand_n;
         key_code  <= code_n;
         key_valid <= valid_n;
      end
   end

   assign key_held = (state == HELD) || (state == CONFIRM_RELEASE);

endmodule
